// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out shift register with its load/shift control.
// A WIDTH-bit word is taken on a valid/ready handshake and then streamed out
// one bit per enabled clock, with a LAST marker on the final bit.
//
// Handshake: a word transfers on a rising edge where load_valid & load_ready
// are both high. load_valid may be raised at any time. While load_ready is
// low, load_valid is ignored, so upstream must keep load_valid and pin steady
// until the transfer happens. load_ready is high when IDLE, or when SHIFT is
// consuming its final bit this cycle (cnt == 0 and shift_en), so that
// consecutive words stream out with no gap.
module piso_shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pin,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             out_bit;

  // Next value of each stage when shifting: take the neighbour away from the output end, zero fill.
  always_comb begin
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign load_ready = (state == IDLE) | ((state == SHIFT) & (cnt == '0) & shift_en);
  assign accept     = load_valid & load_ready;

  // Control FSM, shift register and remaining-bit counter (cnt = bits left minus 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= pin;
            cnt   <= CNT_MAX;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt != '0) begin
              sreg <= sreg_shifted;
              cnt  <= cnt - CW'(1);
            end else if (accept) begin
              sreg <= pin;
              cnt  <= CNT_MAX;
            end else begin
              sreg  <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Serial outputs are decoded from registers only, so there is no input-to-sout path.
  assign out_bit    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign sout       = busy & out_bit;
  assign last       = busy & (cnt == '0);
  assign state_dbg  = busy;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: an MSB-first and an LSB-first instance share all
// inputs, so every scenario checks both bit orders against the loaded word.
module tb_piso_shift_ctrl;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] pin;
  logic       shift_en;

  logic m_load_ready, m_sout, m_sout_valid, m_last, m_busy, m_state_dbg;
  logic l_load_ready, l_sout, l_sout_valid, l_last, l_busy, l_state_dbg;

  int checks;
  int errors;

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_load_ready),
    .pin(pin), .shift_en(shift_en), .sout(m_sout), .sout_valid(m_sout_valid),
    .last(m_last), .busy(m_busy), .state_dbg(m_state_dbg)
  );

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
    .pin(pin), .shift_en(shift_en), .sout(l_sout), .sout_valid(l_sout_valid),
    .last(l_last), .busy(l_busy), .state_dbg(l_state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer a word from IDLE with shift_en high; returns at the negedge showing bit 0.
  task automatic start_word(input logic [7:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    pin        = w;
    shift_en   = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (m_sout !== 1'b0 || l_sout !== 1'b0) begin errors++; $display("FAIL reset_sout got %b/%b exp 0/0", m_sout, l_sout); end
    checks++; if (m_sout_valid !== 1'b0 || l_sout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b exp 0/0", m_sout_valid, l_sout_valid); end
    checks++; if (m_last !== 1'b0 || m_busy !== 1'b0 || m_state_dbg !== 1'b0) begin errors++; $display("FAIL reset_last_busy got %b%b%b exp 000", m_last, m_busy, m_state_dbg); end
    checks++; if (m_load_ready !== 1'b1 || l_load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b exp 1/1", m_load_ready, l_load_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_first;
    logic [7:0] w;
    w = 8'hA5;
    start_word(w);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (m_sout !== w[7-c]) begin errors++; $display("FAIL msb_sout c=%0d got %b exp %b", c, m_sout, w[7-c]); end
      checks++; if (m_sout_valid !== 1'b1 || m_busy !== 1'b1) begin errors++; $display("FAIL msb_valid c=%0d got %b%b exp 11", c, m_sout_valid, m_busy); end
      checks++; if (m_last !== (c == 7)) begin errors++; $display("FAIL msb_last c=%0d got %b exp %b", c, m_last, (c == 7)); end
    end
    @(negedge clk);
    checks++; if (m_sout !== 1'b0 || m_sout_valid !== 1'b0 || m_last !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL msb_idle got %b%b%b%b exp 0000", m_sout, m_sout_valid, m_last, m_busy); end
    checks++; if (m_load_ready !== 1'b1) begin errors++; $display("FAIL msb_idle_ready got %b exp 1", m_load_ready); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] words [2];
    logic [7:0] w;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      w = words[k];
      start_word(w);
      for (int c = 0; c < 8; c++) begin
        if (c > 0) @(negedge clk);
        checks++; if (l_sout !== w[c]) begin errors++; $display("FAIL lsb_sout w=%h c=%0d got %b exp %b", w, c, l_sout, w[c]); end
        checks++; if (l_last !== (c == 7) || l_sout_valid !== 1'b1) begin errors++; $display("FAIL lsb_last w=%h c=%0d got %b%b exp %b1", w, c, l_last, l_sout_valid, (c == 7)); end
      end
      @(negedge clk);
      checks++; if (l_sout_valid !== 1'b0 || l_load_ready !== 1'b1 || l_sout !== 1'b0) begin errors++; $display("FAIL lsb_idle got %b%b%b exp 010", l_sout_valid, l_load_ready, l_sout); end
    end
  endtask

  task automatic test_stall;
    logic [7:0] w;
    int idx [11];
    int nvalid;
    int nlast;
    w = 8'hA5;
    idx = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    nvalid = 0;
    nlast = 0;
    start_word(w);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      shift_en = !(c >= 1 && c <= 3);
      if (m_sout_valid === 1'b1) nvalid++;
      if (m_last === 1'b1) nlast++;
      checks++; if (m_sout !== w[7-idx[c]]) begin errors++; $display("FAIL stall_msb c=%0d got %b exp %b", c, m_sout, w[7-idx[c]]); end
      checks++; if (l_sout !== w[idx[c]]) begin errors++; $display("FAIL stall_lsb c=%0d got %b exp %b", c, l_sout, w[idx[c]]); end
      checks++; if (m_load_ready !== (c == 10)) begin errors++; $display("FAIL stall_ready c=%0d got %b exp %b", c, m_load_ready, (c == 10)); end
    end
    shift_en = 1'b1;
    @(negedge clk);
    checks++; if (nvalid != 11 || nlast != 1) begin errors++; $display("FAIL stall_counts got valid=%0d last=%0d exp 11 1", nvalid, nlast); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", m_busy); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] stream;
    stream = 16'hA53C;
    @(negedge clk);
    load_valid = 1'b1;
    pin        = 8'hA5;
    shift_en   = 1'b1;
    @(negedge clk);
    pin = 8'h3C;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 15) load_valid = 1'b0;
      checks++; if (m_sout !== stream[15-c] || m_sout_valid !== 1'b1) begin errors++; $display("FAIL b2b_msb c=%0d got %b%b exp %b1", c, m_sout, m_sout_valid, stream[15-c]); end
      checks++; if (l_sout !== stream[(c < 8) ? (8 + c) : (c - 8)]) begin errors++; $display("FAIL b2b_lsb c=%0d got %b", c, l_sout); end
      checks++; if (m_load_ready !== (c == 7 || c == 15) || m_last !== (c == 7 || c == 15)) begin errors++; $display("FAIL b2b_ready c=%0d got %b%b exp %b", c, m_load_ready, m_last, (c == 7 || c == 15)); end
    end
    @(negedge clk);
    checks++; if (m_sout_valid !== 1'b0 || l_sout_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b exp 0/0", m_sout_valid, l_sout_valid); end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] w;
    start_word(8'hFF);
    for (int c = 1; c < 4; c++) @(negedge clk);
    checks++; if (m_sout !== 1'b1 || m_busy !== 1'b1) begin errors++; $display("FAIL rst_pre got %b%b exp 11", m_sout, m_busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_sout !== 1'b0 || l_sout !== 1'b0 || m_sout_valid !== 1'b0 || l_sout_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out got %b%b%b%b exp 0000", m_sout, l_sout, m_sout_valid, l_sout_valid); end
    checks++; if (m_busy !== 1'b0 || m_last !== 1'b0 || m_load_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ctl got %b%b%b exp 001", m_busy, m_last, m_load_ready); end
    @(negedge clk);
    rst = 1'b0;
    w = 8'h81;
    start_word(w);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (m_sout !== w[7-c] || l_sout !== w[c]) begin errors++; $display("FAIL rst_reload c=%0d got %b/%b exp %b/%b", c, m_sout, l_sout, w[7-c], w[c]); end
    end
    @(negedge clk);
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_reload_idle got %b exp 0", m_busy); end
  endtask

  task automatic test_ignore_load;
    logic [7:0] w;
    w = 8'hA5;
    start_word(w);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      load_valid = (c == 2);
      if (c == 2) pin = 8'h00;
      checks++; if (m_sout !== w[7-c] || l_sout !== w[c]) begin errors++; $display("FAIL ignore_sout c=%0d got %b/%b exp %b/%b", c, m_sout, l_sout, w[7-c], w[c]); end
    end
    load_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_busy !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b/%b exp 0/0", m_busy, l_busy); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    pin        = 8'h00;
    shift_en   = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
